dmem_access_responder: RTL
==========================

Name: dmem_access_responder

Overview:
- Data-memory responder that executes the load/store commands issued by the single-cycle control path: signal_MemRead, signal_MemWrite, signal_sb/sh/sw and the load-width selects signal_MemtoReg1/2.
- Backing store is a byte-wide RAM, so each access is serialized one byte per cycle under a valid/ready handshake.
- Loads return sign- or zero-extended 32-bit data.
- Stores perform byte, halfword or word writes in big-endian (MIPS) byte order.

Parameters:
- ADDR_W, 10, byte-address width; memory depth = 2**ADDR_W bytes.
- INIT_ZERO, 1, when 1 all bytes read as 0 after reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  command present.
- req_ready  output  1  responder can accept a command (high only in IDLE).
- signal_MemRead  input  1  load command.
- signal_MemWrite  input  1  store command.
- signal_sb  input  1  store byte.
- signal_sh  input  1  store halfword.
- signal_sw  input  1  store word.
- signal_MemtoReg1  input  1  load width select, high bit.
- signal_MemtoReg2  input  1  load width select, low bit.
- load_unsigned  input  1  1 = zero-extend (lbu/lhu), 0 = sign-extend.
- addr  input  32  byte address; only [ADDR_W-1:0] are used.
- wdata  input  32  store data; right-justified for sb/sh.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  command rejected, valid with resp_valid.

Behaviour:
- Reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, FSM=IDLE, byte counter=0. Memory is zeroed if INIT_ZERO=1.
- Handshake: a command is accepted when req_valid && req_ready. All inputs are latched on that edge and may change afterwards. Exactly one resp_valid pulse follows each accepted command; there is no back-pressure on the response.
- Width decode:
  - Loads: {MemtoReg1,MemtoReg2} = 00 word(4), 01 byte(1), 11 half(2), 10 illegal.
  - Stores: exactly one of sb/sh/sw gives 1/2/4 bytes; zero or several set is illegal.
- Error cases, detected in IDLE at accept:
  - MemRead and MemWrite both set, or neither set.
  - Illegal width.
  - Misalignment (see Optional Feature).
- FSM states and transitions:
  - IDLE: accept a command. Legal command -> ACCESS with cnt=0. Illegal command -> RESP with err=1; memory untouched.
  - ACCESS: one byte per cycle at address base+cnt.
    - Stores write the big-endian byte wdata[8*(N-1-cnt)+:8].
    - Loads shift each byte into an accumulator, MSB first.
    - cnt==N-1 -> RESP.
  - RESP: resp_valid=1 for one cycle, then -> IDLE. resp_rdata carries the N-byte value sign-extended (load_unsigned=0) or zero-extended.
- Latency, accept edge to resp_valid high: N+1 cycles for legal commands (byte 2, half 3, word 5), 1 cycle for errors.
- Address wrap: base+cnt is computed modulo 2**ADDR_W. Upper addr bits are ignored.
- Next command: earliest acceptance is the cycle after RESP; back-to-back throughput is one command per N+2 cycles.
- Read-after-write: a load following a store returns the stored value. There is no cross-command hazard because accesses are serialized.
- Reset mid-operation: the FSM returns to IDLE immediately and no response is issued. Bytes already written by an in-flight store keep their new values; remaining bytes are unchanged.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]!=0, is rejected with resp_err=1 after 1 cycle and no memory effect.
- Undefined: the low address bits are masked to natural alignment (addr[0] cleared for half, addr[1:0] cleared for word) and the access proceeds normally. No misalignment error exists in this build.

Test Plan:
- sw, addr=0x10, wdata=0xDEADBEEF, then lw addr=0x10 -> store response after 5 cycles; load returns 0xDEADBEEF with err=0. Bytes 0x10..0x13 = DE,AD,BE,EF.
- sb, addr=0x21, wdata=0x00000080; then lb addr=0x21 -> 0xFFFFFF80; then lbu addr=0x21 -> 0x00000080. Each byte access has 2-cycle latency.
- sh, addr=0x30, wdata=0x00008001; then lh -> 0xFFFF8001 and lhu -> 0x00008001. Byte 0x30=0x80, byte 0x31=0x01.
- MemRead=MemWrite=1 at addr 0x40 -> err=1 after 1 cycle, rdata=0; a following lw from 0x40 returns 0.
- lw at addr=0x13:
  - With DMEM_ALIGN_CHECK_EN -> err=1.
  - Without the macro -> returns the word at 0x10, 0xDEADBEEF.
- Start sw 0x11223344 to 0x50, assert rst_n=0 after 2 ACCESS cycles -> no response; req_ready=1 after reset; bytes 0x50/0x51 = 11/22, 0x52/0x53 unchanged. Run with INIT_ZERO=0 to observe preserved contents.

Source files
------------

// File: rtl/dmem_access_responder.sv
// ---------------------------------------------------------------------------
// dmem_access_responder
//
// Data-memory responder for the single-cycle control path. Each accepted
// load/store is serialized over a byte-wide RAM, one byte per cycle, in
// big-endian (MIPS) byte order. Loads return sign- or zero-extended data;
// stores write 1, 2 or 4 bytes.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid / req_ready command handshake (ready only while idle)
//   signal_MemRead/Write  load / store command
//   signal_sb/sh/sw       store width (exactly one must be set)
//   signal_MemtoReg1/2    load width: 00 word, 01 byte, 11 half, 10 illegal
//   load_unsigned         1 = zero-extend, 0 = sign-extend
//   addr, wdata           byte address (low ADDR_W bits used), store data
//   resp_valid            one-cycle response pulse
//   resp_rdata, resp_err  extended load data (0 for stores/errors), reject flag
//
// Build option:
//   DMEM_ALIGN_CHECK_EN   defined: misaligned half/word commands are rejected.
//                         undefined: low address bits are masked to natural
//                         alignment and the access proceeds.
//
// States:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a command, req_ready high
//   ST_ACCESS | transferring one byte per cycle at base+cnt
//   ST_RESP   | resp_valid high for exactly one cycle
// ---------------------------------------------------------------------------
module dmem_access_responder #(
    parameter int ADDR_W    = 10,
    parameter int INIT_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        signal_MemRead,
    input  logic        signal_MemWrite,
    input  logic        signal_sb,
    input  logic        signal_sh,
    input  logic        signal_sw,
    input  logic        signal_MemtoReg1,
    input  logic        signal_MemtoReg2,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_q;
    logic [1:0]          cnt_q;
    logic [1:0]          len_m1_q;      // byte count minus one: 0, 1 or 3
    logic                is_load_q;
    logic                unsigned_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [23:0]         acc_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic [31:0]         resp_rdata_q;
    logic                resp_err_q;

    logic [7:0]          mem_q [2**ADDR_W];

    // Command decode, evaluated on the live inputs in IDLE
    logic [1:0]          len_m1_d;
    logic                width_ok_d;
    logic                misalign_d;
    logic                cmd_err_d;
    logic [ADDR_W-1:0]   base_d;

    logic                unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W];

    always_comb begin
        len_m1_d   = 2'd0;
        width_ok_d = 1'b0;
        if (signal_MemRead) begin
            case ({signal_MemtoReg1, signal_MemtoReg2})
                2'b00:   begin len_m1_d = 2'd3; width_ok_d = 1'b1; end
                2'b01:   begin len_m1_d = 2'd0; width_ok_d = 1'b1; end
                2'b11:   begin len_m1_d = 2'd1; width_ok_d = 1'b1; end
                default: begin len_m1_d = 2'd0; width_ok_d = 1'b0; end
            endcase
        end else begin
            case ({signal_sb, signal_sh, signal_sw})
                3'b100:  begin len_m1_d = 2'd0; width_ok_d = 1'b1; end
                3'b010:  begin len_m1_d = 2'd1; width_ok_d = 1'b1; end
                3'b001:  begin len_m1_d = 2'd3; width_ok_d = 1'b1; end
                default: begin len_m1_d = 2'd0; width_ok_d = 1'b0; end
            endcase
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        misalign_d = ((len_m1_d == 2'd1) && addr[0]) ||
                     ((len_m1_d == 2'd3) && (addr[1:0] != 2'b00));
        base_d     = addr[ADDR_W-1:0];
    end
`else
    always_comb begin
        misalign_d = 1'b0;
        case (len_m1_d)
            2'd1:    base_d = {addr[ADDR_W-1:1], 1'b0};
            2'd3:    base_d = {addr[ADDR_W-1:2], 2'b00};
            default: base_d = addr[ADDR_W-1:0];
        endcase
    end
`endif

    assign cmd_err_d = (signal_MemRead == signal_MemWrite) || !width_ok_d || misalign_d;

    // Datapath for the byte currently being transferred
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        rd_byte;
    logic [1:0]        byte_sel;
    logic [7:0]        wr_byte;
    logic              mem_we;
    logic [31:0]       load_val;
    logic [31:0]       load_ext;

    assign mem_addr = addr_q + ADDR_W'(cnt_q);   // wraps modulo the depth
    assign rd_byte  = mem_q[mem_addr];
    assign byte_sel = len_m1_q - cnt_q;          // first byte is the most significant
    assign mem_we   = (state_q == ST_ACCESS) && !is_load_q;

    always_comb begin
        case (byte_sel)
            2'd0:    wr_byte = wdata_q[7:0];
            2'd1:    wr_byte = wdata_q[15:8];
            2'd2:    wr_byte = wdata_q[23:16];
            default: wr_byte = wdata_q[31:24];
        endcase
    end

    // Value as it will stand once the current (last) byte is shifted in
    assign load_val = {acc_q, rd_byte};

    always_comb begin
        case (len_m1_q)
            2'd0:    load_ext = unsigned_q ? {24'h0, load_val[7:0]}
                                           : {{24{load_val[7]}}, load_val[7:0]};
            2'd1:    load_ext = unsigned_q ? {16'h0, load_val[15:0]}
                                           : {{16{load_val[15]}}, load_val[15:0]};
            default: load_ext = load_val;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            len_m1_q     <= 2'd0;
            is_load_q    <= 1'b0;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            acc_q        <= 24'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        len_m1_q    <= len_m1_d;
                        is_load_q   <= signal_MemRead;
                        unsigned_q  <= load_unsigned;
                        addr_q      <= base_d;
                        wdata_q     <= wdata;
                        acc_q       <= 24'h0;
                        cnt_q       <= 2'd0;
                        req_ready_q <= 1'b0;
                        if (cmd_err_d) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    acc_q <= {acc_q[15:0], rd_byte};
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == len_m1_q) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= is_load_q ? load_ext : 32'h0;
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Byte RAM. With INIT_ZERO the array is cleared by reset; otherwise its
    // contents survive reset, including bytes of an interrupted store.
    generate
        if (INIT_ZERO != 0) begin : g_mem_init
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < 2**ADDR_W; i++) begin
                        mem_q[i] <= 8'h00;
                    end
                end else if (mem_we) begin
                    mem_q[mem_addr] <= wr_byte;
                end
            end
        end else begin : g_mem_noinit
            always_ff @(posedge clk) begin
                if (mem_we) begin
                    mem_q[mem_addr] <= wr_byte;
                end
            end
        end
    endgenerate

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
